// File: rtl/regfile_write_sequencer_if.sv
// Bus bundle between the WB stage, the write sequencer and the regfile write
// port: the two-slot writeback pair with its handshake, plus the registered
// single write port.
interface regfile_write_sequencer_if #(
    parameter int unsigned DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wr0_en;
    logic              in_wr1_en;
    logic [4:0]        in_wr0_reg;
    logic [4:0]        in_wr1_reg;
    logic [DATA_W-1:0] in_wr0_data;
    logic [DATA_W-1:0] in_wr1_data;
    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;

    // WB stage / environment side
    modport master (
        output in_valid, in_wr0_en, in_wr1_en, in_wr0_reg, in_wr1_reg,
               in_wr0_data, in_wr1_data,
        input  in_ready, RegWrite, WriteRegister, WriteData
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_wr0_en, in_wr1_en, in_wr0_reg, in_wr1_reg,
               in_wr0_data, in_wr1_data,
        output in_ready, RegWrite, WriteRegister, WriteData
    );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Write-side front end of the 32x64 register file. Accepts up to two
// writebacks per cycle, queues them in order (slot 0 before slot 1) and
// drains them through the single registered write port at one per cycle.
// Writes to X31 (XZR) and disabled slots are dropped.
// Optional feature macro: REGFILE_WSEQ_FORWARD_EN builds the forwarding
// lookup over pending writes; when undefined the fwd_* outputs tie to 0.
module regfile_write_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    regfile_write_sequencer_if.slave     wb,
    input  logic [4:0]                   fwd_reg1,
    input  logic [4:0]                   fwd_reg2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         drained
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [4:0]  XZR   = 5'd31;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [4:0]        reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              transfer;
    logic              push0;
    logic              push1;
    logic              pop;

    // Handshake, push qualification and pop decision from registered state
    always_comb begin
        wb.in_ready = occupancy <= OCC_W'(DEPTH - 2);
        transfer    = wb.in_valid && wb.in_ready;
        push0       = transfer && wb.in_wr0_en && (wb.in_wr0_reg != XZR);
        push1       = transfer && wb.in_wr1_en && (wb.in_wr1_reg != XZR);
        pop         = occupancy != '0;
        drained     = (occupancy == '0) && !wb.RegWrite;
    end

    // Queue storage; slot 1 lands behind slot 0 only if slot 0 was pushed
    always_ff @(posedge clk) begin
        if (push0) begin
            reg_q[wr_ptr]  <= wb.in_wr0_reg;
            data_q[wr_ptr] <= wb.in_wr0_data;
        end
        if (push1) begin
            reg_q[wr_ptr + PTR_W'(push0)]  <= wb.in_wr1_reg;
            data_q[wr_ptr + PTR_W'(push0)] <= wb.in_wr1_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            wr_ptr    <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            occupancy <= occupancy + OCC_W'(push0) + OCC_W'(push1) - OCC_W'(pop);
        end
    end

    // Registered regfile write port; address/data hold when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb.RegWrite      <= 1'b0;
            wb.WriteRegister <= XZR;
            wb.WriteData     <= '0;
        end else if (pop) begin
            wb.RegWrite      <= 1'b1;
            wb.WriteRegister <= reg_q[rd_ptr];
            wb.WriteData     <= data_q[rd_ptr];
        end else begin
            wb.RegWrite      <= 1'b0;
        end
    end

`ifdef REGFILE_WSEQ_FORWARD_EN
    logic [4:0]        lk_reg  [2];
    logic              lk_hit  [2];
    logic [DATA_W-1:0] lk_data [2];

    // Youngest-match lookup: output register first, then queue entries from
    // oldest to newest so a later match overrides an earlier one
    always_comb begin
        lk_reg[0] = fwd_reg1;
        lk_reg[1] = fwd_reg2;
        for (int unsigned p = 0; p < 2; p++) begin
            lk_hit[p]  = 1'b0;
            lk_data[p] = '0;
            if (lk_reg[p] != XZR) begin
                if (wb.RegWrite && (wb.WriteRegister == lk_reg[p])) begin
                    lk_hit[p]  = 1'b1;
                    lk_data[p] = wb.WriteData;
                end
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if ((k < 32'(occupancy)) &&
                        (reg_q[rd_ptr + PTR_W'(k)] == lk_reg[p])) begin
                        lk_hit[p]  = 1'b1;
                        lk_data[p] = data_q[rd_ptr + PTR_W'(k)];
                    end
                end
            end
        end
        fwd_hit1  = lk_hit[0];
        fwd_hit2  = lk_hit[1];
        fwd_data1 = lk_data[0];
        fwd_data2 = lk_data[1];
    end
`else
    logic unused_fwd;

    // Forwarding not built; lookup addresses are deliberately ignored
    always_comb begin
        fwd_hit1   = 1'b0;
        fwd_hit2   = 1'b0;
        fwd_data1  = '0;
        fwd_data2  = '0;
        unused_fwd = ^{fwd_reg1, fwd_reg2};
    end
`endif

endmodule
